// File: rtl/conv_window_gen.sv
// Sliding KSIZE x KSIZE window generator over a raster-order image stream.
// Optional macro WIN_CNT_EN adds a per-frame window counter output win_cnt.
module conv_window_gen #(
  parameter int IMA   = 8,
  parameter int KSIZE = 7,
  parameter int COLS  = 28,
  parameter int ROWS  = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IMA-1:0]                pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [IMA*KSIZE*KSIZE-1:0]    ima_out,
  output logic                          win_valid,
`ifdef WIN_CNT_EN
  output logic [15:0]                   win_cnt,
`endif
  output logic                          frame_done
);

  localparam int NUM   = KSIZE * KSIZE;
  localparam int SRLEN = (KSIZE - 1) * COLS + KSIZE;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] KC   = CW'(KSIZE - 1);
  localparam logic [RW-1:0] KR   = RW'(KSIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [IMA*NUM-1:0]   ima_out_q, ima_out_d;
  // Line buffers and window flattened into one raster-delay line: sr[0] is
  // the newest pixel, sr[d] the pixel accepted d pixels earlier.
  logic [IMA-1:0]       sr_q [SRLEN];
  logic [IMA-1:0]       sr_d [SRLEN];
`ifdef WIN_CNT_EN
  logic [15:0]          win_cnt_q, win_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    ima_out_d    = ima_out_q;
    sr_d         = sr_q;
`ifdef WIN_CNT_EN
    win_cnt_d    = win_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
`ifdef WIN_CNT_EN
          win_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        if (pix_valid) begin
          sr_d[0] = pix_in;
          for (int n = 1; n < SRLEN; n++) sr_d[n] = sr_q[n-1];
          // Window complete only once KSIZE-1 full rows and columns are behind us.
          if (row_q >= KR && col_q >= KC) begin
            win_valid_d = 1'b1;
            for (int i = 0; i < KSIZE; i++)
              for (int j = 0; j < KSIZE; j++)
                ima_out_d[IMA*(i*KSIZE+j) +: IMA] = sr_d[(KSIZE-1-i)*COLS + (KSIZE-1-j)];
`ifdef WIN_CNT_EN
            win_cnt_d = win_cnt_q + 16'd1;
`endif
          end
          if (col_q == CMAX) begin
            col_d = '0;
            if (row_q == RMAX) begin
              row_d        = '0;
              state_d      = DONE;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      ima_out_q    <= '0;
`ifdef WIN_CNT_EN
      win_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      ima_out_q    <= ima_out_d;
`ifdef WIN_CNT_EN
      win_cnt_q    <= win_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign pix_ready  = (state_q == RUN);
  assign ima_out    = ima_out_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef WIN_CNT_EN
  assign win_cnt    = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against an array-based image/window model.
module tb_conv_window_gen;

  localparam int IMA = 8, KSIZE = 7, COLS = 28, ROWS = 28;
  localparam int NUM = KSIZE * KSIZE;
  localparam int NPIX = ROWS * COLS;
  localparam int NWIN = (ROWS - KSIZE + 1) * (COLS - KSIZE + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [IMA-1:0] pix_in = '0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [IMA*NUM-1:0] ima_out;
  logic win_valid;
  logic frame_done;
`ifdef WIN_CNT_EN
  logic [15:0] win_cnt;
`endif

  conv_window_gen #(.IMA(IMA), .KSIZE(KSIZE), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .ima_out(ima_out), .win_valid(win_valid),
`ifdef WIN_CNT_EN
    .win_cnt(win_cnt),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  logic [IMA-1:0] img [NPIX];
  logic [IMA*NUM-1:0] last_win = '0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ready"}, 512'(pix_ready), 512'(0));
    check_val({tag, "_wv"}, 512'(win_valid), 512'(0));
    check_val({tag, "_fd"}, 512'(frame_done), 512'(0));
    check_val({tag, "_ima"}, 512'(ima_out), 512'(last_win));
  endtask

  // mode: 0 valid always, 1 valid toggles, 2 random valid plus stray start pulses
  task automatic run_frame(input int mode, input bit pattern, input int abort_at);
    int idx, nwin, r, c, budget;
    bit acc, exp_wv, first;
    for (int p = 0; p < NPIX; p++)
      img[p] = pattern ? IMA'(p) : IMA'($urandom);
    start = 1'b1;
    pix_valid = 1'b0;
    check_val("start_ready", 512'(pix_ready), 512'(0));
    step();
    start = 1'b0;
    idx = 0; nwin = 0; first = 1'b1; budget = 0;
    while (idx < NPIX && budget < 10000) begin
      budget++;
      case (mode)
        0: pix_valid = 1'b1;
        1: pix_valid = (budget % 2) == 1;
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      start = (mode == 2) && ($urandom_range(0, 15) == 0);
      pix_in = img[idx];
      #1;
      check_val("run_ready", 512'(pix_ready), 512'(1));
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        last_win = '0;
        check_quiet("abort");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          pix_valid = 1'b1;
          step();
          check_quiet("post_abort");
        end
        return;
      end
      acc = pix_valid;
      step();
      start = 1'b0;
      exp_wv = 1'b0;
      if (acc) begin
        r = idx / COLS;
        c = idx % COLS;
        if (r >= KSIZE - 1 && c >= KSIZE - 1) begin
          exp_wv = 1'b1;
          for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
              last_win[IMA*(i*KSIZE+j) +: IMA] = img[(r-KSIZE+1+i)*COLS + (c-KSIZE+1+j)];
        end
        idx++;
      end
      check_val("win_valid", 512'(win_valid), 512'(exp_wv));
      check_val("ima_out", 512'(ima_out), 512'(last_win));
      check_val("frame_done", 512'(frame_done), 512'(acc && idx == NPIX));
      if (exp_wv) begin
        nwin++;
        if (first) begin
          first = 1'b0;
          check_val("first_win_pix", 512'(idx - 1), 512'(174));
          if (pattern) begin
            check_val("slot0", 512'(ima_out[IMA*0 +: IMA]), 512'(0));
            check_val("slot6", 512'(ima_out[IMA*6 +: IMA]), 512'(6));
            check_val("slot42", 512'(ima_out[IMA*42 +: IMA]), 512'(168));
            check_val("slot48", 512'(ima_out[IMA*48 +: IMA]), 512'(174));
          end
        end
      end
`ifdef WIN_CNT_EN
      check_val("win_cnt", 512'(win_cnt), 512'(nwin));
`endif
    end
    check_val("frame_budget", 512'(idx), 512'(NPIX));
    check_val("win_count", 512'(nwin), 512'(NWIN));
    pix_valid = 1'b1;
    #1;
    check_val("done_ready", 512'(pix_ready), 512'(0));
    step();
    check_quiet("idle_after");
`ifdef WIN_CNT_EN
    check_val("win_cnt_hold", 512'(win_cnt), 512'(NWIN));
`endif
    pix_valid = 1'b0;
  endtask

  initial begin
    #2;
    check_val("rst_ready", 512'(pix_ready), 512'(0));
    check_val("rst_wv", 512'(win_valid), 512'(0));
    check_val("rst_fd", 512'(frame_done), 512'(0));
    check_val("rst_ima", 512'(ima_out), 512'(0));
    step();
    rst_n = 1'b1;
    step();

    run_frame(0, 1'b1, -1);
    step();
    run_frame(1, 1'b1, -1);

    for (int k = 0; k < 5; k++) begin
      pix_valid = 1'b1;
      pix_in = IMA'($urandom);
      step();
      check_quiet("idle_valid");
    end
    run_frame(2, 1'b0, -1);

    run_frame(0, 1'b0, 300);
    run_frame(2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMA, default 8: pixel width in bits.
REQ-002 Parameter KSIZE, default 7: window edge; window holds NUM = KSIZE*KSIZE = 49 pixels.
REQ-003 Parameter COLS, default 28: image width in pixels.
REQ-004 Parameter ROWS, default 28: image height in pixels.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins a frame.
REQ-008 pix_in  input  IMA  raster-order pixel, row 0 col 0 first.
REQ-009 pix_valid  input  1  pix_in valid.
REQ-010 pix_ready  output  1  block accepts pix_in this cycle.
REQ-011 ima_out  output  IMA*NUM  flattened 7x7 window, feeds the conv MAC image bus.
REQ-012 win_valid  output  1  ima_out holds a new complete window this cycle.
REQ-013 frame_done  output  1  one-cycle pulse after last pixel of frame accepted.

Function
REQ-014 States IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE: pix_ready=0; start=1 -> RUN, clears row/col counters.
REQ-016 RUN: pix_ready=1; a pixel is accepted on cycles with pix_valid=1 and pix_ready=1; pix_valid=0 cycles hold all state.
REQ-017 Column counter 0..COLS-1 advances per accepted pixel; wraps to 0 and increments row counter at COLS-1.
REQ-018 Acceptance of pixel (ROWS-1, COLS-1) -> DONE; DONE asserts frame_done for one cycle, pix_ready=0, then IDLE.
REQ-019 start outside IDLE is ignored.
REQ-020 KSIZE-1 line buffers of COLS pixels store the previous rows; plus a KSIZE x KSIZE shift window updated per accepted pixel.
REQ-021 Accepting pixel (r,c) with r>=KSIZE-1 and c>=KSIZE-1 -> next cycle win_valid=1 and ima_out = rows r-6..r, cols c-6..c.
REQ-022 Slot k = i*KSIZE+j (i=0 top/oldest row, j=0 leftmost column) occupies ima_out[IMA*(k+1)-1 : IMA*k].
REQ-023 No window for c<KSIZE-1 (row wrap) or r<KSIZE-1; win_valid=0 those cycles and when no pixel was accepted.
REQ-024 win_valid is a single-cycle pulse per window; ima_out holds its last value between windows.
REQ-025 Windows per frame = (ROWS-KSIZE+1)*(COLS-KSIZE+1) = 484 at defaults.
REQ-026 Line buffer contents need not be cleared; windows only form after KSIZE-1 full rows of the current frame.
REQ-027 No backpressure from the consumer: the downstream MAC pipeline accepts one window per cycle.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, counters 0, pix_ready=0, win_valid=0, frame_done=0, ima_out=0.
REQ-029 Reset mid-frame aborts the frame; no window or frame_done follows until a new start.

Configuration
REQ-030 Macro WIN_CNT_EN defined: extra output win_cnt [15:0], cleared on reset and on start, incremented on each win_valid, holds final count after frame_done.
REQ-031 WIN_CNT_EN undefined: win_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 Defaults, start, pixel value = (r*28+c) mod 256 streamed with pix_valid=1 -> first win_valid cycle after pixel 174 accepted; slot0=0, slot6=6, slot42=168, slot48=174.
REQ-033 Same frame -> exactly 484 win_valid pulses; none following pixels at c<6; frame_done one cycle after pixel 783; win_cnt=484 with WIN_CNT_EN.
REQ-034 pix_valid toggled 1/0 every cycle -> identical window contents and count as REQ-032/033, win_valid only after accepting cycles.
REQ-035 rst_n low at pixel 300, then start and full frame -> no output before restart; next frame yields 484 correct windows, first again after pixel 174.
REQ-036 start pulsed during RUN -> ignored, counters and windows unaffected; pix_ready=0 in IDLE/DONE with pix_valid=1 -> no pixel accepted.
